// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: frame gate between the YUV input FIFO and sobel_ctrl, with row flush and output counting.
// Define SOBEL_SEQ_TIMEOUT_EN to build the DRAIN watchdog that drives err_timeout.
module sobel_frame_sequencer #(
    parameter logic [23:0] FLUSH_DATA  = 24'h008080,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        start,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic [7:0]  cfg_threshold,
    output logic [7:0]  threshold,
    input  logic [23:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [23:0] dp_data,
    output logic        dp_valid,
    input  logic        dp_ready,
    input  logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [23:0] pix_in_cnt,
    output logic [23:0] pix_out_cnt
);

    typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;

    state_t      state;
    logic [11:0] width_q;
    logic [11:0] flush_cnt;
    logic [23:0] total;
    logic [23:0] out_cnt_nxt;
    logic        in_fire;
    logic        out_fire;
    logic        cfg_ok;
    logic        count_out;

`ifdef SOBEL_SEQ_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] idle_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    assign in_fire     = dp_valid & dp_ready;
    assign out_fire    = out_valid & out_ready;
    assign cfg_ok      = (cfg_width >= 12'd3) && (cfg_height >= 12'd3);
    assign count_out   = out_fire && (state == FEED || state == FLUSH || state == DRAIN);
    assign out_cnt_nxt = pix_out_cnt + {23'd0, out_fire};

    // FEED forwards the FIFO handshake with zero latency; FLUSH substitutes the neutral pixel.
    always_comb begin
        dp_valid  = 1'b0;
        dp_data   = '0;
        src_ready = 1'b0;
        case (state)
            FEED: begin
                dp_valid  = src_valid;
                dp_data   = src_data;
                src_ready = dp_ready;
            end
            FLUSH: begin
                dp_valid = 1'b1;
                dp_data  = FLUSH_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state       <= IDLE;
            width_q     <= '0;
            flush_cnt   <= '0;
            total       <= '0;
            threshold   <= '0;
            pix_in_cnt  <= '0;
            pix_out_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (count_out) begin
                pix_out_cnt <= out_cnt_nxt;
            end
            case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        state       <= FEED;
                        busy        <= 1'b1;
                        width_q     <= cfg_width;
                        total       <= {12'd0, cfg_width} * {12'd0, cfg_height};
                        threshold   <= cfg_threshold;
                        pix_in_cnt  <= '0;
                        pix_out_cnt <= '0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                    end
                end
                FEED: begin
                    if (in_fire) begin
                        pix_in_cnt <= pix_in_cnt + 24'd1;
                        if (pix_in_cnt + 24'd1 == total) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // flush_cnt == width_q marks the (width+1)-th flush pixel
                    if (in_fire) begin
                        if (flush_cnt == width_q) begin
                            state <= DRAIN;
`ifdef SOBEL_SEQ_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end else begin
                            flush_cnt <= flush_cnt + 12'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_cnt_nxt >= total) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef SOBEL_SEQ_TIMEOUT_EN
                    else if (out_fire) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sobel_frame_sequencer.md
# sobel_frame_sequencer

- Frame-level controller that sits between the upstream YUV input FIFO and the `sobel_ctrl` datapath.
- Accepts a start command with frame geometry and threshold, then gates exactly width×height pixels into the datapath.
- After the last real pixel, injects flush pixels so the line buffers and the 3×3 window drain the final rows.
- Counts datapath outputs, signals completion, and optionally aborts on a stalled drain.

## Interface
Parameters:
- `FLUSH_DATA`, 24'h008080: pixel injected during flush (Y=0, neutral chroma).
- `TIMEOUT_CYC`, 65535: maximum cycles in DRAIN without an output handshake (used only with the macro).

Ports:
- `clk`  in  1  single clock.
- `rst_p`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command; sampled only in IDLE.
- `cfg_width`  in  12  pixels per line; legal range 3..4095.
- `cfg_height`  in  12  lines per frame; legal range 3..4095.
- `cfg_threshold`  in  8  edge threshold for the frame.
- `threshold`  out  8  threshold latched at start; drives the datapath.
- `src_data`  in  24  upstream FIFO data.
- `src_valid`  in  1  upstream FIFO data valid.
- `src_ready`  out  1  pop request to the upstream FIFO.
- `dp_data`  out  24  to `sobel_ctrl` `input_fifo_data_yuv`.
- `dp_valid`  out  1  to `sobel_ctrl` `input_fifo_valid_yuv`.
- `dp_ready`  in  1  from `sobel_ctrl` `input_fifo_ready_yuv`.
- `out_valid`  in  1  monitored datapath `output_fifo_valid`.
- `out_ready`  in  1  monitored downstream `output_fifo_ready`.
- `busy`  out  1  high in FEED, FLUSH and DRAIN.
- `done`  out  1  one-cycle pulse at frame completion.
- `err_timeout`  out  1  sticky; cleared by reset or the next accepted start.
- `pix_in_cnt`  out  24  real pixels accepted in the current frame.
- `pix_out_cnt`  out  24  output handshakes in the current frame.

## Operation
Fire signals:
- in_fire = `dp_valid & dp_ready`.
- out_fire = `out_valid & out_ready`.

FSM states: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE: `start` latches width, height and threshold, computes total = width×height (24-bit unsigned, no overflow at 4095×4095), clears both counters and `err_timeout`, then goes to FEED.
- FEED: `dp_valid=src_valid`, `src_ready=dp_ready`, `dp_data=src_data`. Each in_fire increments `pix_in_cnt`. The in_fire that makes the count equal total moves the FSM to FLUSH.
- FLUSH: `src_ready=0`, `dp_valid=1`, `dp_data=FLUSH_DATA`. The flush counter counts in_fires. After width+1 flush pixels, go to DRAIN. Flush pixels do not increment `pix_in_cnt`.
- DRAIN: `dp_valid=0`, `src_ready=0`. When `pix_out_cnt` reaches total, go to DONE.
- DONE: `done=1` for one cycle, then return to IDLE.
- Output counting: `pix_out_cnt` increments on every out_fire in FEED, FLUSH and DRAIN. Out_fires in IDLE and DONE are ignored.
- Early completion: if `pix_out_cnt` reaches total in FEED or FLUSH, the FSM still completes the flush, then goes through DRAIN to DONE.
- Zero cycles are never spent in DRAIN beyond the cycle needed to evaluate the count.
- Illegal config (width<3 or height<3): `start` is ignored and the FSM stays in IDLE.
- `threshold` holds its latched value through DONE and IDLE until the next accepted start.

## Timing
- Reset values: `threshold`=0, `busy`=0, `done`=0, `err_timeout`=0, `dp_valid`=0, `dp_data`=0, `src_ready`=0, both counters=0, state=IDLE.
- The FSM and counters are registered. In FEED, `dp_valid`, `dp_data` and `src_ready` are combinational pass-throughs, giving zero-cycle forwarding.
- `busy` rises the cycle after the accepted `start`.
- `done` asserts the cycle after the out_fire that reaches total while in DRAIN.
- `done` asserts the cycle after entering DRAIN if total was already reached.
- `busy` is low in the `done` cycle.
- `start` while busy or in DONE is ignored; there is no queuing.
- A simultaneous in_fire and out_fire in one cycle updates both counters.
- `rst_p` asserted mid-frame returns to IDLE on the next edge. No partial `done` is produced.
- The datapath is reset separately by its owner.

## Configuration
Macro `SOBEL_SEQ_TIMEOUT_EN`.
- Defined:
  - A 16-bit idle counter runs in DRAIN. It is cleared on each out_fire.
  - Reaching `TIMEOUT_CYC` sets `err_timeout` and forces DONE, so `done` still pulses with `pix_out_cnt` < total.
- Undefined:
  - No counter is built and `err_timeout` is tied to 0.
  - DRAIN waits indefinitely.

## Test plan
- Width=4, height=3, threshold=8'h40, src always valid, `dp_ready`=1, outputs returned one per in_fire → `pix_in_cnt`=12, then exactly 5 flush pixels of 24'h008080, then `done` pulses once with `pix_out_cnt`=12 and `threshold`=8'h40.
- Same frame with `dp_ready` toggling every other cycle and `src_valid` gapped → no pixel duplicated or dropped, and `src_ready` is never high while `dp_ready`=0.
- `start` pulsed during FEED with width=8 → ignored; geometry and threshold remain from the first start.
- Width=2, height=5, `start` → FSM stays IDLE and `busy` stays 0.
- `rst_p` asserted mid-FLUSH → next cycle `busy`=0, counters=0, `dp_valid`=0, and no `done`.
- With `SOBEL_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=100, and outputs stopping at 10 of 12 → `err_timeout`=1 and `done` pulses 101 cycles after the last out_fire. Without the macro, the FSM stays in DRAIN and `busy`=1.
